// File: rtl/conv3x3_stream.sv
// conv3x3_stream: single-clock raster 3x3 convolution with double-buffered signed weights.
// Build option `CONV_ROUND_EN adds 2^(SHIFT-1) before the final shift (round half up).

module conv3x3_stream #(
    parameter int BITWIDTH = 8,
    parameter int WBITS    = 8,
    parameter int COLS     = 640,
    parameter int ROWS     = 480,
    parameter int SHIFT    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din_valid,
    input  logic [BITWIDTH-1:0] din,
    output logic                din_ready,
    input  logic                weight_in_valid,
    input  logic [WBITS-1:0]    weight,
    input  logic [3:0]          weight_addr,
    output logic [BITWIDTH-1:0] dout,
    output logic                dout_valid,
    output logic                dout_sof,
    output logic                dout_eol,
    output logic                ready,
    output logic                frame_done
);
    // Handshake: a pixel moves on a cycle with din_valid && din_ready; dout is
    // qualified by dout_valid only (no backpressure), markers ride with it.

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int PW = BITWIDTH + WBITS + 1;
    localparam int SW = BITWIDTH + WBITS + 5;
    localparam logic signed [SW-1:0] MAX_PIX = SW'((2 ** BITWIDTH) - 1);
`ifdef CONV_ROUND_EN
    localparam logic signed [SW-1:0] ROUND_ADD = (SHIFT > 0) ? SW'(1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`endif

    typedef enum logic {LOAD, RUN} state_t;
    state_t state;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          pending;
    logic signed [WBITS-1:0] shadow [9];
    logic signed [WBITS-1:0] active [9];
    logic signed [WBITS-1:0] w_eff  [9];

    logic [BITWIDTH-1:0] lb1 [COLS];
    logic [BITWIDTH-1:0] lb2 [COLS];
    logic [BITWIDTH-1:0] lb1_rd, lb2_rd;
    logic [BITWIDTH-1:0] win   [3][3];
    logic [BITWIDTH-1:0] win_n [3][3];

    logic signed [PW-1:0] prod_n [9];
    logic signed [PW-1:0] s1_prod [9];
    logic                 s1_valid, s1_sof, s1_eol;
    logic signed [SW-1:0] sum_c, s2_sum, rounded, shifted;
    logic                 s2_valid, s2_sof, s2_eol;
    logic [BITWIDTH-1:0]  clamp;

    logic accept, wr_tap, commit, first_px, last_col, last_row, copy_now, win_ok;

    assign accept   = din_valid && din_ready;
    assign wr_tap   = weight_in_valid && (weight_addr <= 4'd8);
    assign commit   = weight_in_valid && (weight_addr == 4'd9);
    assign first_px = (col == '0) && (row == '0);
    assign last_col = (col == CW'(COLS - 1));
    assign last_row = (row == RW'(ROWS - 1));
    assign copy_now = accept && first_px && pending && (state == RUN);
    assign win_ok   = (row >= RW'(2)) && (col >= CW'(2));
    assign lb1_rd   = lb1[col];
    assign lb2_rd   = lb2[col];

    // Read-before-write: lb2 takes the row that lb1 is about to forget.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= din;
            lb2[col] <= lb1_rd;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            win_n[i][0] = win[i][1];
            win_n[i][1] = win[i][2];
        end
        win_n[0][2] = lb2_rd;
        win_n[1][2] = lb1_rd;
        win_n[2][2] = din;
    end

    // Pixel (0,0) already multiplies with the bank it is about to install.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_eff[k]  = copy_now ? shadow[k] : active[k];
            prod_n[k] = PW'($signed({1'b0, win_n[k / 3][k % 3]})) * PW'(w_eff[k]);
        end
    end

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < 9; k++) sum_c = sum_c + SW'(s1_prod[k]);
    end

    always_comb begin
`ifdef CONV_ROUND_EN
        rounded = s2_sum + ROUND_ADD;
`else
        rounded = s2_sum;
`endif
        shifted = rounded >>> SHIFT;
        if (shifted[SW-1])          clamp = '0;
        else if (shifted > MAX_PIX) clamp = '1;
        else                        clamp = shifted[BITWIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            din_ready  <= 1'b0;
            ready      <= 1'b0;
            pending    <= 1'b0;
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                shadow[k]  <= '0;
                active[k]  <= '0;
                s1_prod[k] <= '0;
                win[k / 3][k % 3] <= '0;
            end
            s1_valid   <= 1'b0;
            s1_sof     <= 1'b0;
            s1_eol     <= 1'b0;
            s2_sum     <= '0;
            s2_valid   <= 1'b0;
            s2_sof     <= 1'b0;
            s2_eol     <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            dout_eol   <= 1'b0;
        end else begin
            frame_done <= accept && last_col && last_row;
            if (wr_tap) shadow[weight_addr] <= weight;

            case (state)
                LOAD: begin
                    if (commit) begin
                        for (int k = 0; k < 9; k++) active[k] <= shadow[k];
                        state     <= RUN;
                        din_ready <= 1'b1;
                        ready     <= 1'b1;
                    end
                end
                RUN: begin
                    if (copy_now) begin
                        for (int k = 0; k < 9; k++) active[k] <= shadow[k];
                        pending <= 1'b0;
                    end
                    if (commit) pending <= 1'b1;
                end
                default: state <= LOAD;
            endcase

            if (accept) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                for (int k = 0; k < 9; k++) win[k / 3][k % 3] <= win_n[k / 3][k % 3];
            end

            for (int k = 0; k < 9; k++) s1_prod[k] <= prod_n[k];
            s1_valid <= accept && win_ok;
            s1_sof   <= accept && (row == RW'(2)) && (col == CW'(2));
            s1_eol   <= accept && win_ok && last_col;

            s2_sum   <= sum_c;
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_eol   <= s1_eol;

            dout_valid <= s2_valid;
            dout_sof   <= s2_sof;
            dout_eol   <= s2_eol;
            if (s2_valid) dout <= clamp;
        end
    end

endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Parametrised single-clock 3x3 convolution engine: successor to the dual-clock 3x3 filter in the PE array. Accepts a raster pixel stream, keeps two circular line buffers, and multiplies each full 3x3 window by signed, double-buffered weights. Output is shifted, rounded and saturated. It sits between the pixel source and the PE output collector and emits one result per interior pixel with frame and line markers.

## Interface
Parameters:
- BITWIDTH, 8, unsigned pixel width (in and out)
- WBITS, 8, signed two's-complement weight width
- COLS, 640, pixels per line (>= 3)
- ROWS, 480, lines per frame (>= 3)
- SHIFT, 0, right-shift applied to the accumulated sum (0..WBITS+4)

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- din_valid  in  1  pixel present
- din  in  BITWIDTH  pixel
- din_ready  out  1  pixel accepted when din_valid & din_ready
- weight_in_valid  in  1  weight write strobe
- weight  in  WBITS  weight value
- weight_addr  in  4  0..8 = tap index (row*3+col); 9 = commit; 10..15 ignored
- dout  out  BITWIDTH  filtered pixel
- dout_valid  out  1  dout qualifier (no backpressure)
- dout_sof  out  1  first output of frame, with dout_valid
- dout_eol  out  1  last output of a line, with dout_valid
- ready  out  1  high in RUN
- frame_done  out  1  one-cycle pulse after last pixel of a frame accepted

## Operation
- Weight banks: shadow[0..8] written when weight_in_valid & addr<=8. active[0..8] feeds the multipliers.
- FSM LOAD (reset state): din_ready=0, ready=0. A commit (addr 9) copies shadow to active and moves to RUN on the next cycle.
- FSM RUN: din_ready=1, ready=1. A commit sets the pending flag. Pending copies shadow to active at the end of the cycle in which pixel (0,0) is accepted, then clears. A commit when col=row=0 is applied at the next (0,0) accept.
- Counters col (0..COLS-1), row (0..ROWS-1) advance per accepted pixel. col wraps to 0 and row increments; after (ROWS-1,COLS-1) both return to 0.
- Line buffers: two COLS-deep memories indexed by col, read-before-write. lb1 holds row r-1 and lb2 holds row r-2. A 3x3 register window shifts per accept.
- Window valid when accepted pixel has row>=2 and col>=2. Tap k=i*3+j multiplies pixel (row-2+i, col-2+j).
- Arithmetic: pixel zero-extended to signed BITWIDTH+1. Each product has width BITWIDTH+WBITS+1. The sum has width BITWIDTH+WBITS+5 with no overflow possible. Then arithmetic shift right by SHIFT, then clamp to [0, 2^BITWIDTH-1].
- dout_sof with window at (2,2); dout_eol with window at col=COLS-1.
- No output for border pixels: (ROWS-2)*(COLS-2) outputs per frame.

## Timing
- Pipeline: accept at T; products registered T+1; sum registered T+2; dout/dout_valid/markers registered, visible T+3.
- Throughput 1 pixel/cycle in RUN; gaps in din_valid stall nothing and produce gaps in output.
- frame_done is high in cycle T+1 after accepting (ROWS-1,COLS-1).
- The in-flight pipeline is unaffected by weight swaps: stage 1 of pixel (0,0) uses the new weights, and all earlier pixels use the old weights.
- Reset values: dout=0, dout_valid=0, dout_sof=0, dout_eol=0, din_ready=0, ready=0, frame_done=0. Counters, window, pipeline, both banks and pending are 0; state is LOAD. Line buffer contents need not be cleared.
- Reset mid-frame: the next accepted pixel is (0,0), and the in-flight pipeline is discarded (no dout_valid after rst).
- Weight write and commit cannot collide (single address). A write to shadow in the same cycle as a pending copy is not visible until the next commit.

## Configuration
- CONV_ROUND_EN defined: with SHIFT>0, add 2^(SHIFT-1) to the sum before shifting (round half up).
- CONV_ROUND_EN undefined: pure truncating arithmetic shift.
- With SHIFT=0 the macro has no effect.

## Test plan
- COLS=4, ROWS=4, SHIFT=0, centre weight (k=4) =1, others 0, commit. Frame of pixels 0..15 gives exactly 4 outputs: 5,6,9,10. Flags: sof on 5; eol on 6 and 10; frame_done once; each output 3 cycles after its triggering accept.
- All weights =1, all pixels 255: every output is 255 (saturated from 2295). All weights =1, all pixels 10: every output is 90.
- Centre weight =-1 (0xFF), pixels 200: outputs 0 (negative clamp).
- SHIFT=1, weight k=0 =1, all pixels 5: 2 with CONV_ROUND_EN undefined, 3 with it defined.
- In RUN, write centre =2 and commit mid-frame. Remainder of the frame keeps weight 1. Next frame outputs are doubled starting from its first output.
- Assert rst during row 2 of a frame: all outputs are 0 in the next cycle and ready=0. After reload and commit, a fresh frame produces correct results with counters restarted.
